motion_search_ctrl: RTL and testbench
=====================================

# motion_search_ctrl

Parametrised motion-compensation search controller: for one 16x16 luma block, fetches the current block from frame A and a (16+2R)-row x 48-pixel reference window from frame B, then runs an exhaustive integer-pel SAD search over dx, dy in [-R, +R]. Returns the best motion vector and its SAD. Sits between the two frame SRAMs (one read/write port each, 1-cycle read latency) and the downstream residual/encoder stage. It supersedes the fixed-size loader with selectable pixel width, search range, frame geometry, and actual vector computation.

## Interface
- PIX_W, 8: bits per pixel. WORD_W = 16*PIX_W; one SRAM word holds one 16-pixel block row. Pixel i (i=0 leftmost) is at bits [i*PIX_W +: PIX_W].
- SRCH_R, 4: search range R, legal 1..16.
- FRAME_ROWS, 720: pixel rows per frame.
- FRAME_COLS, 80: words per pixel row.
- ROW_AW, 10 / COL_AW, 7: row/column address widths. SRAM address = {row, col}.
- SAD_W derived = PIX_W+8. MV_W derived = 6, signed.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  request; sampled only in IDLE
- blk_col  in  COL_AW  block word column; pixel x0 = 16*blk_col
- blk_row  in  ROW_AW-4  block row index; pixel y0 = 16*blk_row
- csA / addrA  out  1 / ROW_AW+COL_AW  frame A read strobe (active-high) and address
- doutA  in  WORD_W  frame A read data, valid the cycle after csA
- csB / addrB / doutB: same for frame B
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle result pulse
- mv_x, mv_y  out  MV_W signed  best vector
- sad_min  out  SAD_W  SAD of best vector

## Operation
- States: IDLE -> LOAD -> DRAIN -> SEARCH -> DONE -> IDLE.
- IDLE: csA=csB=0, busy=0. start=1 latches blk_col/blk_row and enters LOAD. start in any other state is ignored.
- LOAD issues 3*(16+2R) cycles, one read per port per cycle.
  - Port B walks window rows y0-R .. y0+15+R, row-major. Each row reads words blk_col-1, blk_col, blk_col+1.
  - Port A reads rows y0..y0+15 at word blk_col in the first 16 cycles, then idles (csA=0).
- Out-of-frame window rows (<0 or >=FRAME_ROWS) or words (<0 or >=FRAME_COLS): no read issued (csB=0 that cycle); the storage slot is zero-filled.
- DRAIN: 1 cycle; captures the last read data.
- SEARCH: candidates in order dy=-R..+R (outer), dx=-R..+R (inner), 16 cycles each, one block row per cycle.
  - Per row: sum of 16 |cur - ref| terms, where ref pixel = window pixel at column 16+dx+i, row R+dy+r.
  - Accumulation is unsigned, SAD_W bits, and cannot overflow.
- Candidate validity: 0 <= x0+dx and x0+dx+15 <= 16*FRAME_COLS-1, and 0 <= y0+dy and y0+dy+15 <= FRAME_ROWS-1.
  - Invalid candidates still consume 16 cycles; their result is discarded.
- Best-candidate update: only on strictly smaller SAD, so the first candidate in scan order wins ties. (0,0) is always valid, so a result always exists.
- DONE: registers mv_x, mv_y, sad_min; done=1 for one cycle; next state IDLE.
- Results hold until the next DONE.
- rst_n low at any time (including mid-LOAD/SEARCH): immediately IDLE; csA, csB, addrA, addrB, busy, done, mv_x, mv_y, sad_min all 0. The aborted search produces no done.

## Timing
- Read protocol: addr and cs presented in cycle n; data consumed at edge n+1. SRAM write enable is never driven by this block.
- start sampled at edge 0. busy=1 from cycle 1. done=1 exactly in cycle T = 3*(16+2R) + 16*(2R+1)^2 + 2. For R=4: T=1370.
- busy drops in the same cycle done rises. start may be reasserted in the following cycle.
- Latency is data-independent and frame-position-independent.

## Test plan
- Frames A=B with random content, block (blk_col=10, blk_row=10) -> mv=(0,0), sad_min=0, done exactly 1370 cycles after start (R=4).
- Frame B = A shifted so that B(x+3, y-2) = A(x, y), interior block -> mv_x=+3, mv_y=-2, sad_min=0.
- Corner block (0,0) with B = A shifted by (-2,-2) -> no out-of-frame csB reads; best valid candidate reported; no candidate with dx<0 or dy<0 is ever selected.
- Flat frames, A all 10 and B all 12 -> every SAD=512; tie resolves to first valid scan candidate, (-4,-4) for an interior block.
- start pulsed repeatedly while busy -> ignored: single done, result unchanged.
- rst_n dropped at cycle 500 of a search, then a new start -> all outputs 0 during reset, no done for the aborted run, new run completes with correct result at T.

Source files
------------

// File: rtl/motion_search_ctrl.sv
// motion_search_ctrl
//   Exhaustive integer-pel SAD motion search for one 16x16 luma block.
//   Loads the current block from frame A and a (16+2R) x 48-pixel reference
//   window from frame B, then scores every (dx, dy) in [-R, +R]^2 and reports
//   the lowest-SAD vector (first in scan order on ties).
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   start               request, sampled only while idle
//   blk_col, blk_row    block position: x0 = 16*blk_col, y0 = 16*blk_row
//   csA/addrA/doutA     frame A read strobe, address {row, col}, read data (+1 cycle)
//   csB/addrB/doutB     frame B read strobe, address {row, col}, read data (+1 cycle)
//   busy                high from accepted start until done
//   done                one-cycle result pulse
//   mv_x, mv_y          best vector (signed)
//   sad_min             SAD of best vector
module motion_search_ctrl #(
    parameter int  PIX_W      = 8,
    parameter int  SRCH_R     = 4,
    parameter int  FRAME_ROWS = 720,
    parameter int  FRAME_COLS = 80,
    parameter int  ROW_AW     = 10,
    parameter int  COL_AW     = 7,
    localparam int WORD_W     = 16 * PIX_W,
    localparam int SAD_W      = PIX_W + 8,
    localparam int MV_W       = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [COL_AW-1:0]        blk_col,
    input  logic [ROW_AW-5:0]        blk_row,
    output logic                     csA,
    output logic [ROW_AW+COL_AW-1:0] addrA,
    input  logic [WORD_W-1:0]        doutA,
    output logic                     csB,
    output logic [ROW_AW+COL_AW-1:0] addrB,
    input  logic [WORD_W-1:0]        doutB,
    output logic                     busy,
    output logic                     done,
    output logic signed [MV_W-1:0]   mv_x,
    output logic signed [MV_W-1:0]   mv_y,
    output logic [SAD_W-1:0]         sad_min
);

    localparam int WIN_ROWS = 16 + 2 * SRCH_R;
    localparam int LD_CYC   = 3 * WIN_ROWS;
    localparam int WR_AW    = $clog2(WIN_ROWS);
    localparam int LK_W     = $clog2(LD_CYC);

    typedef enum logic [2:0] {IDLE, LOAD, DRAIN, SEARCH, DONE} state_t;
    state_t state, state_nx;

    logic [COL_AW-1:0]      col_q;
    logic [ROW_AW-5:0]      row_q;
    logic [LK_W-1:0]        ld_k;
    logic [WR_AW-1:0]       ld_row;
    logic [1:0]             ld_word;

    // Read-data capture pipeline: slot/valid info follows the address by one cycle
    logic                   capa_en;
    logic [3:0]             capa_row;
    logic                   capb_en;
    logic                   capb_vld;
    logic [WR_AW-1:0]       capb_row;
    logic [1:0]             capb_word;

    logic [WORD_W-1:0]      cur [16];
    logic [WORD_W-1:0]      win [WIN_ROWS][3];

    logic signed [MV_W-1:0] dx, dy, best_dx, best_dy;
    logic [3:0]             srow;
    logic [SAD_W-1:0]       acc, best_sad;
    logic                   best_found;

    logic signed [15:0]     x0, y0, ld_py, ld_wx, cx, cy;
    logic [ROW_AW-1:0]      ya;
    logic                   b_ok, a_on, cand_ok, last_row, last_cand, take;
    logic [WR_AW-1:0]       win_sel;
    logic [5:0]             sx;
    logic [3*WORD_W-1:0]    row_flat;
    logic [WORD_W-1:0]      ref_row;
    logic [PIX_W-1:0]       pa, pb;
    logic [SAD_W-1:0]       row_sad, cand_sum;

    always_comb begin
        x0 = '0;
        y0 = '0;
        x0[COL_AW+3:4] = col_q;
        y0[ROW_AW-1:4] = row_q;

        // Load addressing: window row y0-R+ld_row, word blk_col-1+ld_word
        ld_py = y0 - 16'(SRCH_R) + 16'(ld_row);
        ld_wx = 16'(col_q) + 16'(ld_word) - 16'sd1;
        b_ok  = !ld_py[15] && (ld_py < 16'(FRAME_ROWS)) &&
                !ld_wx[15] && (ld_wx < 16'(FRAME_COLS));
        a_on  = ld_k < LK_W'(16);
        ya    = y0[ROW_AW-1:0] + ROW_AW'(ld_k[3:0]);

        // Candidate must lie fully inside the frame
        cx      = x0 + 16'(dx);
        cy      = y0 + 16'(dy);
        cand_ok = !cx[15] && !cy[15] &&
                  (cx + 16'sd15 < 16'(16 * FRAME_COLS)) &&
                  (cy + 16'sd15 < 16'(FRAME_ROWS));

        // Reference row R+dy+srow; 48-pixel row shifted so pixel 16+dx lands at 0
        win_sel  = WR_AW'(SRCH_R) + WR_AW'(dy) + WR_AW'(srow);
        row_flat = {win[win_sel][2], win[win_sel][1], win[win_sel][0]};
        sx       = 6'd16 + 6'(dx);
        ref_row  = WORD_W'(row_flat >> (32'(sx) * PIX_W));

        pa      = '0;
        pb      = '0;
        row_sad = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            pa      = cur[srow][i*PIX_W +: PIX_W];
            pb      = ref_row[i*PIX_W +: PIX_W];
            row_sad = row_sad + SAD_W'((pa > pb) ? pa - pb : pb - pa);
        end

        cand_sum  = acc + row_sad;
        last_row  = srow == 4'd15;
        last_cand = (dx == MV_W'(SRCH_R)) && (dy == MV_W'(SRCH_R));
        take      = last_row && cand_ok && (!best_found || cand_sum < best_sad);
    end

    always_comb begin
        state_nx = state;
        csA      = 1'b0;
        addrA    = '0;
        csB      = 1'b0;
        addrB    = '0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nx = LOAD;
            end
            LOAD: begin
                busy = 1'b1;
                csA  = a_on;
                if (a_on) addrA = {ya, col_q};
                csB  = b_ok;
                if (b_ok) addrB = {ld_py[ROW_AW-1:0], ld_wx[COL_AW-1:0]};
                if (ld_k == LK_W'(LD_CYC - 1)) state_nx = DRAIN;
            end
            DRAIN: begin
                busy     = 1'b1;
                state_nx = SEARCH;
            end
            SEARCH: begin
                busy = 1'b1;
                if (last_row && last_cand) state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            col_q      <= '0;
            row_q      <= '0;
            ld_k       <= '0;
            ld_row     <= '0;
            ld_word    <= '0;
            capa_en    <= 1'b0;
            capa_row   <= '0;
            capb_en    <= 1'b0;
            capb_vld   <= 1'b0;
            capb_row   <= '0;
            capb_word  <= '0;
            dx         <= '0;
            dy         <= '0;
            srow       <= '0;
            acc        <= '0;
            best_sad   <= '0;
            best_dx    <= '0;
            best_dy    <= '0;
            best_found <= 1'b0;
            mv_x       <= '0;
            mv_y       <= '0;
            sad_min    <= '0;
        end else begin
            state     <= state_nx;
            capa_en   <= (state == LOAD) && a_on;
            capa_row  <= ld_k[3:0];
            capb_en   <= state == LOAD;
            capb_vld  <= b_ok;
            capb_row  <= ld_row;
            capb_word <= ld_word;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        col_q   <= blk_col;
                        row_q   <= blk_row;
                        ld_k    <= '0;
                        ld_row  <= '0;
                        ld_word <= '0;
                    end
                end
                LOAD: begin
                    ld_k <= ld_k + LK_W'(1);
                    if (ld_word == 2'd2) begin
                        ld_word <= '0;
                        ld_row  <= ld_row + WR_AW'(1);
                    end else begin
                        ld_word <= ld_word + 2'd1;
                    end
                end
                DRAIN: begin
                    dx         <= MV_W'(-SRCH_R);
                    dy         <= MV_W'(-SRCH_R);
                    srow       <= '0;
                    acc        <= '0;
                    best_found <= 1'b0;
                end
                SEARCH: begin
                    srow <= srow + 4'd1;
                    acc  <= last_row ? '0 : cand_sum;
                    if (take) begin
                        best_found <= 1'b1;
                        best_sad   <= cand_sum;
                        best_dx    <= dx;
                        best_dy    <= dy;
                    end
                    if (last_row) begin
                        if (dx == MV_W'(SRCH_R)) begin
                            dx <= MV_W'(-SRCH_R);
                            dy <= dy + MV_W'(1);
                        end else begin
                            dx <= dx + MV_W'(1);
                        end
                        // Final candidate's own result is folded in here, since
                        // best_* only updates at this same edge
                        if (last_cand) begin
                            mv_x    <= take ? dx : best_dx;
                            mv_y    <= take ? dy : best_dy;
                            sad_min <= take ? cand_sum : best_sad;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Pixel storage; out-of-frame window words are written as zero
    always_ff @(posedge clk) begin
        if (capa_en) cur[capa_row] <= doutA;
        if (capb_en) win[capb_row][capb_word] <= capb_vld ? doutB : '0;
    end

endmodule

// File: tb/tb_motion_search_ctrl.sv
module tb_motion_search_ctrl;

    localparam int PIX_W  = 8;
    localparam int R      = 4;
    localparam int FR     = 720;
    localparam int FC     = 80;
    localparam int ROW_AW = 10;
    localparam int COL_AW = 7;
    localparam int WORD_W = 16 * PIX_W;
    localparam int AW     = ROW_AW + COL_AW;
    localparam int T      = 3 * (16 + 2 * R) + 16 * (2 * R + 1) * (2 * R + 1) + 2;

    logic                     clk     = 1'b0;
    logic                     rst_n   = 1'b0;
    logic                     start   = 1'b0;
    logic [COL_AW-1:0]        blk_col = '0;
    logic [ROW_AW-5:0]        blk_row = '0;
    logic                     csA, csB;
    logic [AW-1:0]            addrA, addrB;
    logic [WORD_W-1:0]        doutA = '0;
    logic [WORD_W-1:0]        doutB = '0;
    logic                     busy, done;
    logic signed [5:0]        mv_x, mv_y;
    logic [PIX_W+7:0]         sad_min;

    motion_search_ctrl #(
        .PIX_W(PIX_W), .SRCH_R(R), .FRAME_ROWS(FR), .FRAME_COLS(FC),
        .ROW_AW(ROW_AW), .COL_AW(COL_AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .blk_col(blk_col), .blk_row(blk_row),
        .csA(csA), .addrA(addrA), .doutA(doutA),
        .csB(csB), .addrB(addrB), .doutB(doutB),
        .busy(busy), .done(done), .mv_x(mv_x), .mv_y(mv_y), .sad_min(sad_min)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          mode = 0;
    int unsigned seed_a = 0;
    int unsigned seed_b = 0;
    int          checks = 0;
    int          passed = 0;
    int          oob = 0;
    int          done_cnt = 0;

    typedef struct {
        int mvx;
        int mvy;
        int sad;
        int cyc;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    task automatic check(string name, longint act, longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Frame content as a function of pixel coordinates
    function automatic int hashpix(int x, int y, int unsigned s);
        int unsigned h;
        h = unsigned'(x * 73856093) ^ unsigned'(y * 19349663) ^ s;
        h = h ^ (h >> 13);
        h = h * 32'h5bd1e995;
        h = h ^ (h >> 15);
        return int'(h & ((32'd1 << PIX_W) - 32'd1));
    endfunction

    function automatic int pix_a(int x, int y);
        if (mode == 3) return 10;
        return hashpix(x, y, seed_a);
    endfunction

    function automatic int pix_b(int x, int y);
        case (mode)
            0:       return pix_a(x, y);
            1:       return pix_a(x - 3, y + 2);   // B(x+3, y-2) = A(x, y)
            2:       return pix_a(x + 2, y + 2);   // B(x-2, y-2) = A(x, y)
            3:       return 12;
            default: return hashpix(x, y, seed_b);
        endcase
    endfunction

    function automatic logic [WORD_W-1:0] word_of(bit is_b, logic [AW-1:0] a);
        logic [WORD_W-1:0] w;
        int row, col, v;
        row = int'(a[AW-1:COL_AW]);
        col = int'(a[COL_AW-1:0]);
        w = '0;
        for (int i = 0; i < 16; i++) begin
            v = is_b ? pix_b(16 * col + i, row) : pix_a(16 * col + i, row);
            w[i*PIX_W +: PIX_W] = PIX_W'(v);
        end
        return w;
    endfunction

    // Exhaustive search straight from the definition of SAD and validity
    function automatic exp_t model(int bc, int br);
        exp_t e;
        int x0, y0, s, d, best;
        x0 = 16 * bc;
        y0 = 16 * br;
        best = -1;
        e.mvx = 0;
        e.mvy = 0;
        e.cyc = 0;
        for (int dy = -R; dy <= R; dy++) begin
            for (int dx = -R; dx <= R; dx++) begin
                if (x0 + dx >= 0 && x0 + dx + 15 <= 16 * FC - 1 &&
                    y0 + dy >= 0 && y0 + dy + 15 <= FR - 1) begin
                    s = 0;
                    for (int r = 0; r < 16; r++) begin
                        for (int i = 0; i < 16; i++) begin
                            d = pix_a(x0 + i, y0 + r) - pix_b(x0 + dx + i, y0 + dy + r);
                            s += (d < 0) ? -d : d;
                        end
                    end
                    if (best < 0 || s < best) begin
                        best  = s;
                        e.mvx = dx;
                        e.mvy = dy;
                    end
                end
            end
        end
        e.sad = best;
        return e;
    endfunction

    // SRAM models: address sampled mid-cycle, data presented after the next edge
    logic              a_pend = 1'b0;
    logic              b_pend = 1'b0;
    logic [WORD_W-1:0] a_data = '0;
    logic [WORD_W-1:0] b_data = '0;

    always @(negedge clk) begin
        a_pend <= csA;
        b_pend <= csB;
        if (csA) a_data <= word_of(1'b0, addrA);
        if (csB) begin
            b_data <= word_of(1'b1, addrB);
            if (int'(addrB[AW-1:COL_AW]) >= FR || int'(addrB[COL_AW-1:0]) >= FC)
                oob <= oob + 1;
        end
    end

    always @(posedge clk) begin
        if (a_pend) doutA <= a_data;
        if (b_pend) doutB <= b_data;
    end

    // Monitor: compare every done pulse against the scoreboard head
    always @(negedge clk) begin
        if (rst_n && done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("mv_x", longint'(mv_x), longint'(mon_e.mvx));
                check("mv_y", longint'(mv_y), longint'(mon_e.mvy));
                check("sad_min", longint'(sad_min), longint'(mon_e.sad));
                check("done_cycle", longint'(cyc), longint'(mon_e.cyc));
                check("busy_at_done", longint'(busy), 0);
            end
        end
    end

    task automatic launch(int bc, int br, output int t1);
        exp_t e;
        e = model(bc, br);
        @(posedge clk);
        #1;
        blk_col = COL_AW'(bc);
        blk_row = (ROW_AW-4)'(br);
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        t1    = cyc;          // cyc value during cycle 1
        e.cyc = t1 + T - 1;   // cyc value during cycle T
        sb.push_back(e);
        check("busy_after_start", longint'(busy), 1);
    endtask

    task automatic wait_result(int t1);
        while (sb.size() != 0 && cyc < t1 + T + 20) @(posedge clk);
        if (sb.size() != 0) begin
            check("done_timeout", longint'(sb.size()), 0);
            sb.delete();
        end
        @(negedge clk);
        #1;
    endtask

    task automatic run(int m, int bc, int br);
        int t1;
        mode   = m;
        seed_a = $urandom;
        seed_b = $urandom;
        oob    = 0;
        launch(bc, br, t1);
        wait_result(t1);
        check("oob_reads", longint'(oob), 0);
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_csA"}, longint'(csA), 0);
        check({tag, "_csB"}, longint'(csB), 0);
        check({tag, "_addrA"}, longint'(addrA), 0);
        check({tag, "_addrB"}, longint'(addrB), 0);
        check({tag, "_busy"}, longint'(busy), 0);
        check({tag, "_done"}, longint'(done), 0);
        check({tag, "_mv_x"}, longint'(mv_x), 0);
        check({tag, "_mv_y"}, longint'(mv_y), 0);
        check({tag, "_sad"}, longint'(sad_min), 0);
    endtask

    initial begin
        int t1, d0;

        #12;
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Identical frames: zero vector, zero SAD
        run(0, 10, 10);
        check("same_mv_x", longint'(mv_x), 0);
        check("same_mv_y", longint'(mv_y), 0);
        check("same_sad", longint'(sad_min), 0);

        // Shifted frame: B(x+3, y-2) = A(x, y)
        run(1, 20, 15);
        check("shift_mv_x", longint'(mv_x), 3);
        check("shift_mv_y", longint'(mv_y), -2);
        check("shift_sad", longint'(sad_min), 0);

        // Corner block: true match lies outside the frame
        run(2, 0, 0);
        check("corner_mv_x_nonneg", longint'(!mv_x[5]), 1);
        check("corner_mv_y_nonneg", longint'(!mv_y[5]), 1);

        // Flat frames: all SADs tie, first valid candidate wins
        run(3, 10, 10);
        check("flat_mv_x", longint'(mv_x), -4);
        check("flat_mv_y", longint'(mv_y), -4);
        check("flat_sad", longint'(sad_min), 512);

        // Random content at frame edges and random positions
        run(4, 79, 44);
        run(4, 0, 44);
        run(4, 79, 0);
        run(3, 0, 0);
        for (int k = 0; k < 3; k++) run(4, int'($urandom_range(0, 79)), int'($urandom_range(0, 44)));

        // start pulses while busy are ignored
        mode   = 4;
        seed_a = $urandom;
        seed_b = $urandom;
        d0     = done_cnt;
        launch(40, 20, t1);
        for (int k = 0; k < 3; k++) begin
            repeat ($urandom_range(50, 400)) @(posedge clk);
            #1;
            blk_col = COL_AW'($urandom_range(0, 79));
            blk_row = (ROW_AW-4)'($urandom_range(0, 44));
            start   = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        wait_result(t1);
        repeat (20) @(posedge clk);
        #1;
        check("single_done", longint'(done_cnt - d0), 1);

        // Reset in the middle of a search: no done, outputs cleared, restart works
        mode   = 4;
        seed_a = $urandom;
        seed_b = $urandom;
        d0     = done_cnt;
        launch(30, 12, t1);
        while (cyc < t1 + 499) @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check_all_zero("midreset");
        repeat (3) @(negedge clk);
        check("midreset_hold_busy", longint'(busy), 0);
        check("midreset_hold_csB", longint'(csB), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (T + 10) @(posedge clk);
        #1;
        check("aborted_no_done", longint'(done_cnt - d0), 0);
        d0 = done_cnt;
        run(4, 30, 12);
        check("restart_done", longint'(done_cnt - d0), 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
